// File: rtl/licznik_wielokanalowy.sv
// licznik_wielokanalowy: multi-channel programmable down-counter/timer.
//
// Each channel has a SZER-bit reload register, a control register
// {en, auto, ie, 2'b00, k[2:0]}, a live SZER-bit count and a 7-bit prescaler.
// While enabled, the prescaler advances every clock and produces a tick every
// 2^k clocks. A tick decrements the count. A tick at count 0 is a terminal
// event: it sets the sticky flag and then either reloads (auto) or stops
// (one-shot).
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-low reset
//   wartosc             write data byte
//   adres               {channel index, register index}
//   zapisz              write strobe
//   dane_out            combinational readback (live count bytes / control)
//   licznik_flaga       per-channel sticky terminal-count flags
//   licznik_flaga_clear per-channel flag clear (takes effect on the next edge)
//   licznik_int         OR of the flags gated by the per-channel ie bits
module licznik_wielokanalowy #(
   parameter int unsigned N_KAN = 4,
   parameter int unsigned SZER  = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [7:0]                                wartosc,
   input  logic [$clog2(N_KAN)+$clog2(SZER/8+1)-1:0] adres,
   input  logic                                      zapisz,
   output logic [7:0]                                dane_out,
   output logic [N_KAN-1:0]                          licznik_flaga,
   input  logic [N_KAN-1:0]                          licznik_flaga_clear,
   output logic                                      licznik_int
);

   localparam int unsigned NB = SZER / 8;           // reload bytes per channel
   localparam int unsigned RW = $clog2(NB + 1);     // register index width
   localparam int unsigned AW = $clog2(N_KAN) + RW; // full address width
   localparam logic [SZER-1:0] JEDEN = SZER'(1);

   logic [N_KAN-1:0][SZER-1:0] reload_q, reload_d;
   logic [N_KAN-1:0][SZER-1:0] cnt_q, cnt_d;
   logic [N_KAN-1:0][6:0]      presk_q, presk_d;
   logic [N_KAN-1:0][2:0]      k_q, k_d;
   logic [N_KAN-1:0]           en_q, en_d;
   logic [N_KAN-1:0]           auto_q, auto_d;
   logic [N_KAN-1:0]           ie_q, ie_d;
   logic [N_KAN-1:0]           flag_q, flag_d;
   logic [N_KAN-1:0]           tick;
   logic [N_KAN-1:0]           terminal;

   logic [RW-1:0] reg_idx;
   logic [AW-1:0] kan_idx;
   int unsigned   reg_n;
   int unsigned   kan_n;
   logic          kan_ok;

   assign reg_idx = adres[RW-1:0];
   assign kan_idx = adres >> RW;
   assign reg_n   = 32'(reg_idx);
   assign kan_n   = 32'(kan_idx);
   // Only matters when N_KAN is not a power of two.
   assign kan_ok  = (kan_n < N_KAN);

   // Low k bits of the prescaler that must all be ones for a tick; k=0 gives
   // an empty mask, i.e. a tick every clock.
   function automatic logic [6:0] maska(input logic [2:0] k);
      return ~(7'h7f << k);
   endfunction

   always_comb begin
      tick     = '0;
      terminal = '0;
      for (int unsigned i = 0; i < N_KAN; i++) begin
         tick[i]     = en_q[i] && ((presk_q[i] & maska(k_q[i])) == maska(k_q[i]));
         terminal[i] = tick[i] && (cnt_q[i] == '0);
      end
   end

   always_comb begin
      reload_d = reload_q;
      cnt_d    = cnt_q;
      presk_d  = presk_q;
      k_d      = k_q;
      en_d     = en_q;
      auto_d   = auto_q;
      ie_d     = ie_q;
      flag_d   = flag_q;
      for (int unsigned i = 0; i < N_KAN; i++) begin
         if (en_q[i]) begin
            presk_d[i] = presk_q[i] + 7'd1;
         end
         if (tick[i]) begin
            if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - JEDEN;
            end else if (auto_q[i]) begin
               cnt_d[i] = reload_q[i];
            end else begin
               en_d[i] = 1'b0;
            end
         end
         // A terminal event on the same edge as a clear keeps the flag set.
         flag_d[i] = (flag_q[i] & ~licznik_flaga_clear[i]) | terminal[i];

         if (zapisz && kan_ok && (kan_n == i)) begin
            for (int unsigned b = 0; b < NB; b++) begin
               if (reg_n == b) begin
                  reload_d[i][8*b +: 8] = wartosc;
               end
            end
            // Control write overrides the tick's effect on en/count/prescaler,
            // but the flag set by a terminal tick above is kept.
            if (reg_n == NB) begin
               en_d[i]   = wartosc[7];
               auto_d[i] = wartosc[6];
               ie_d[i]   = wartosc[5];
               k_d[i]    = wartosc[2:0];
               if (wartosc[7]) begin
                  cnt_d[i]   = reload_q[i];
                  presk_d[i] = '0;
               end else begin
                  cnt_d[i]   = cnt_q[i];
                  presk_d[i] = presk_q[i];
               end
            end
         end
      end
   end

   always_comb begin
      dane_out = '0;
      if (kan_ok) begin
         for (int unsigned i = 0; i < N_KAN; i++) begin
            if (kan_n == i) begin
               for (int unsigned b = 0; b < NB; b++) begin
                  if (reg_n == b) begin
                     dane_out = cnt_q[i][8*b +: 8];
                  end
               end
               if (reg_n == NB) begin
                  dane_out = {en_q[i], auto_q[i], ie_q[i], 2'b00, k_q[i]};
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reload_q <= '0;
         cnt_q    <= '0;
         presk_q  <= '0;
         k_q      <= '0;
         en_q     <= '0;
         auto_q   <= '0;
         ie_q     <= '0;
         flag_q   <= '0;
      end else begin
         reload_q <= reload_d;
         cnt_q    <= cnt_d;
         presk_q  <= presk_d;
         k_q      <= k_d;
         en_q     <= en_d;
         auto_q   <= auto_d;
         ie_q     <= ie_d;
         flag_q   <= flag_d;
      end
   end

   assign licznik_flaga = flag_q;
   assign licznik_int   = |(flag_q & ie_q);

endmodule

// File: doc/licznik_wielokanalowy.md
Name: licznik_wielokanalowy

Overview:
Multi-channel programmable down-counter/timer peripheral for the mikroprocesor. It is the generalised successor of the single 16-bit licznik.
- Parametrised channel count and counter width.
- Per-channel prescaler, one-shot/auto-reload mode, interrupt enable and sticky flag.
- Written byte-wise over the 8-bit CPU data path; drives the interrupt controller with one combined request line.

Parameters:
N_KAN, 4, number of independent timer channels (1..8)
SZER, 16, counter/reload width in bits; multiple of 8 (8..32)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset; assertion immediately forces reset state, release synchronous to clk
wartosc  in  8  write data byte
adres  in  $clog2(N_KAN)+$clog2(SZER/8+1)  [MSBs] channel index, [LSBs] register index
zapisz  in  1  write strobe, sampled on rising clk
dane_out  out  8  combinational readback selected by adres
licznik_flaga  out  N_KAN  per-channel sticky terminal-count flag
licznik_flaga_clear  in  N_KAN  per-channel flag clear, one bit per channel
licznik_int  out  1  interrupt request to interrupt unit = |(licznik_flaga & ie)

Behaviour:
- Register map per channel, register index r:
  - r = 0..SZER/8-1: reload byte r, little-endian (r=0 is LSB).
  - r = SZER/8: control.
  - Writes with r > SZER/8 or channel >= N_KAN are ignored.
- Control bits:
  - [7] en.
  - [6] auto (1 = auto-reload, 0 = one-shot).
  - [5] ie.
  - [4:3] reserved, read 0.
  - [2:0] k, prescaler select: tick every 2^k clocks.
- Reset (rst low): all reload, control, count and prescaler registers = 0; licznik_flaga = 0; licznik_int = 0. dane_out follows cleared registers.
- Reload write: updates reload register only. A running count is unaffected; the new value is used at the next reload or restart.
- Control write with en=1: count <= reload and prescaler <= 0 on the same edge. This applies even if the channel is already running (restart).
- Control write with en=0: count and prescaler freeze; flag is untouched.
- Prescaler: 7-bit per channel, increments each clock while en=1. tick = (presk[k-1:0] all ones), or every cycle when k=0.
- On tick with count != 0: count <= count-1.
- On tick with count == 0 (terminal):
  - flag <= 1.
  - If auto=1: count <= reload.
  - If auto=0: en <= 0, count stays 0.
- Period = (reload+1) * 2^k clocks. With k=0 and a restart at edge T, flag is first high after edge T+reload+1.
- reload = 0, auto=1, k=0: flag re-sets every cycle.
- Flag clear: licznik_flaga_clear[i]=1 clears flag[i] at the next edge. A simultaneous terminal event on that edge wins: flag stays 1.
- Flag is sticky; no auto-clear on read.
- licznik_int is registered-free combinational OR of flags gated by ie. Clearing ie masks the request but keeps the flag.
- Simultaneous control write and terminal tick on the same channel: the write wins (restart or stop). The flag is still set if the tick was terminal.
- Readback: r < SZER/8 returns byte r of the live count (not reload); r = SZER/8 returns control with [4:3]=0; invalid address returns 0.
- Channels are fully independent; no shared prescaler.
- Reset mid-count: immediate clear; no flag or interrupt emitted.

Test Plan:
1. Reset then release; ch0 reload=10 (writes 0x00 to r1, 0x0A to r0), control=0xA0 (en, ie, auto=0, k=0) -> flag[0] and licznik_int rise 11 cycles after control write edge; en auto-clears; count reads 0.
2. ch1 reload=3, control=0xE1 (auto, k=1) -> flag[1] set every 8 clocks; pulse flag_clear[1] between events clears it; clear coinciding with terminal edge leaves flag=1.
3. ch2 running auto, reload=5; rewrite reload=2 mid-count -> current period completes at 6 ticks, subsequent periods 3 ticks; control rewrite 0xC0 mid-count restarts from 2.
4. ch3 control=0x80 (ie=0) -> flag[3] sets, licznik_int stays 0; write control 0xA0 -> licznik_int goes 1 combinationally from flag[3].
5. All four channels enabled with different k; assert rst low mid-count -> all flags, counts, dane_out 0 asynchronously; no interrupt after release until reprogrammed.
6. Write to register index SZER/8+1 and to channel >= N_KAN (when N_KAN not power of 2) -> no state change; readback of invalid address = 0x00.
